// File: rtl/demux_slt_after.sv
// Registered 1-to-2 router for the SLT result path: steers one word into one
// of two single-entry holding registers, each with its own valid/ready handshake.
module demux_slt_after #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] E,
    input  logic             E_valid,
    output logic             E_ready,
    output logic [WIDTH-1:0] S0,
    output logic             S0_valid,
    input  logic             S0_ready,
    output logic [WIDTH-1:0] S1,
    output logic             S1_valid,
    input  logic             S1_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

    hold_state_e      state_q [2];
    hold_state_e      state_d [2];
    logic [WIDTH-1:0] data_q  [2];
    logic [CNTW-1:0]  cnt_q   [2];

    logic [1:0] out_ready;
    logic [1:0] free;
    logic [1:0] load;

    assign out_ready = {S1_ready, S0_ready};

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // can leave one unassigned and infer a latch.
        free    = '0;
        load    = '0;
        E_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
        end

        // A port is free if empty, or if its consumer drains it this cycle.
        for (int k = 0; k < 2; k++) begin
            free[k] = (state_q[k] == EMPTY) || out_ready[k];
        end
        E_ready = free[sel];
        load[0] = E_valid & E_ready & ~sel;
        load[1] = E_valid & E_ready &  sel;

        for (int k = 0; k < 2; k++) begin
            case (state_q[k])
                EMPTY: if (load[k]) state_d[k] = FULL;
                FULL:  if (out_ready[k]) state_d[k] = load[k] ? FULL : EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the holding registers are reset too, because the outputs
            // must read zero after reset rather than stale data.
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                if (load[k]) begin
                    data_q[k] <= E;
                    cnt_q[k]  <= cnt_q[k] + CNTW'(1);
                end
            end
        end
    end

    assign S0       = data_q[0];
    assign S1       = data_q[1];
    assign S0_valid = (state_q[0] == FULL);
    assign S1_valid = (state_q[1] == FULL);
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];

endmodule

// File: tb/tb_demux_slt_after.sv
// Directed bench for demux_slt_after: a per-port scoreboard queue holds the
// words the reference model expects each port to deliver to its consumer.
module tb_demux_slt_after;

    localparam int WIDTH = 32;
    localparam int CNTW  = 8;

    logic             clock;
    logic             reset_n;
    logic             sel;
    logic [WIDTH-1:0] E;
    logic             E_valid;
    logic             E_ready;
    logic [WIDTH-1:0] S0;
    logic             S0_valid;
    logic             S0_ready;
    logic [WIDTH-1:0] S1;
    logic             S1_valid;
    logic             S1_ready;
    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    demux_slt_after #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .sel      (sel),
        .E        (E),
        .E_valid  (E_valid),
        .E_ready  (E_ready),
        .S0       (S0),
        .S0_valid (S0_valid),
        .S0_ready (S0_ready),
        .S1       (S1),
        .S1_valid (S1_valid),
        .S1_ready (S1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0]       m_full;
    logic [CNTW-1:0]  m_cnt [2];
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full   = '0;
        m_cnt[0] = '0;
        m_cnt[1] = '0;
        q0.delete();
        q1.delete();
    endtask

    task automatic check_reset_state();
        check("rst_s0", S0, '0);
        check("rst_s1", S1, '0);
        check("rst_s0_valid", {31'd0, S0_valid}, 32'd0);
        check("rst_s1_valid", {31'd0, S1_valid}, 32'd0);
        check("rst_cnt0", {24'd0, cnt0}, 32'd0);
        check("rst_cnt1", {24'd0, cnt1}, 32'd0);
        sel = 1'b0;
        #1 check("rst_e_ready_sel0", {31'd0, E_ready}, 32'd1);
        sel = 1'b1;
        #1 check("rst_e_ready_sel1", {31'd0, E_ready}, 32'd1);
    endtask

    // Inputs are already driven (just after a rising edge); this checks the
    // pre-edge handshake, advances the model and one clock, then checks state.
    task automatic cycle();
        logic [1:0]       rdy;
        logic             exp_ready;
        logic             acc;
        logic [WIDTH-1:0] d;
        rdy = {S1_ready, S0_ready};
        #1;
        exp_ready = sel ? (!m_full[1] || rdy[1]) : (!m_full[0] || rdy[0]);
        check("e_ready", {31'd0, E_ready}, {31'd0, exp_ready});
        if (m_full[0] && rdy[0]) begin
            d = q0.pop_front();
            check("s0_taken", S0, d);
        end
        if (m_full[1] && rdy[1]) begin
            d = q1.pop_front();
            check("s1_taken", S1, d);
        end
        acc = E_valid && exp_ready;
        for (int k = 0; k < 2; k++) begin
            if (acc && (int'(sel) == k)) m_full[k] = 1'b1;
            else if (rdy[k])             m_full[k] = 1'b0;
        end
        if (acc) begin
            if (sel) begin q1.push_back(E); m_cnt[1] = m_cnt[1] + 1'b1; end
            else     begin q0.push_back(E); m_cnt[0] = m_cnt[0] + 1'b1; end
        end
        @(posedge clock);
        #1;
        check("s0_valid", {31'd0, S0_valid}, {31'd0, m_full[0]});
        check("s1_valid", {31'd0, S1_valid}, {31'd0, m_full[1]});
        check("cnt0", {24'd0, cnt0}, {24'd0, m_cnt[0]});
        check("cnt1", {24'd0, cnt1}, {24'd0, m_cnt[1]});
        if (m_full[0] && q0.size() > 0) check("s0_held", S0, q0[0]);
        if (m_full[1] && q1.size() > 0) check("s1_held", S1, q1[0]);
    endtask

    task automatic drive(input logic s, input logic [WIDTH-1:0] d, input logic v);
        sel     = s;
        E       = d;
        E_valid = v;
    endtask

    initial begin
        reset_n  = 1'b0;
        sel      = 1'b0;
        E        = '0;
        E_valid  = 1'b0;
        S0_ready = 1'b0;
        S1_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_state();
        reset_n = 1'b1;

        // Basic route to port 0: valid for exactly one cycle
        S0_ready = 1'b1;
        S1_ready = 1'b1;
        drive(1'b0, 32'h0000_0001, 1'b1);
        cycle();
        check("basic_s0", S0, 32'h0000_0001);
        drive(1'b0, 32'h0, 1'b0);
        cycle();
        cycle();

        // Backpressure on port 1
        S1_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1);
        cycle();
        drive(1'b1, 32'h0, 1'b0);
        repeat (5) cycle();
        drive(1'b1, 32'h1234_5678, 1'b1);
        cycle();
        check("stall_s1_hold", S1, 32'hDEAD_BEEF);
        S1_ready = 1'b1;
        cycle();
        check("stall_s1_new", S1, 32'h1234_5678);
        check("stall_cnt1", {24'd0, cnt1}, 32'd2);
        S1_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        cycle();

        // Port 0 streams while port 1 stays stalled and full
        S0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h10 + i, 1'b1);
            cycle();
        end
        check("indep_s1", S1, 32'h1234_5678);
        drive(1'b0, 32'h0, 1'b0);
        cycle();

        // Asynchronous reset mid-cycle with both ports full
        S0_ready = 1'b0;
        drive(1'b0, 32'h0000_00AA, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Counter wrap on port 0
        S0_ready = 1'b1;
        S1_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 32'h100 + i, 1'b1);
            cycle();
        end
        check("wrap_cnt0", {24'd0, cnt0}, 32'd0);
        check("wrap_cnt1", {24'd0, cnt1}, 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        cycle();

        // Alternate destinations every cycle
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 32'(i), 1'b1);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0);
        cycle();
        check("alt_cnt0", {24'd0, cnt0}, 32'd5);
        check("alt_cnt1", {24'd0, cnt1}, 32'd5);
        check("alt_s0_last", S0, 32'd8);
        check("alt_s1_last", S1, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
